nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Hardware controller that replaces testbench-driven sequencing of the two-layer MLP datapath.
- Layer 1: generates weight-SRAM and input-SRAM read addresses and MAC1 boundary pulses, then writes each sigmoid result into the hidden buffer.
- Layer 2: streams the hidden buffer against the layer-2 weights through MAC2 and steps the output select.
- Sits in top between the SRAMs, MACs, sigmoid bank and output mux.

Parameters:
- L1_IN, 784, inputs per layer-1 neuron
- L1_OUT, 200, layer-1 neurons (= L2_IN)
- L2_OUT, 10, layer-2 neurons / output classes
- W1_AW, 18, layer-1 weight address width
- IN_AW, 10, input SRAM address width
- W2_AW, 12, layer-2 weight address width
- H_AW, 8, hidden buffer address width
- SEL_W, 7, output select width
- SRAM_LAT, 1, SRAM read latency in cycles (0..3)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin one inference (pulse)
- abort  in  1  synchronous cancel, returns to IDLE
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of inference
- w1_addr  out  W1_AW  layer-1 weight read address
- in_addr  out  IN_AW  input SRAM read address
- acc1_en  out  1  MAC1 accumulate enable, aligned to SRAM data
- mac1_start  out  1  one-cycle pulse: close current layer-1 sum
- mac1_done  in  1  MAC1 result valid
- sig_ready  in  1  sigmoid output valid
- h_we  out  1  hidden buffer write strobe
- h_waddr  out  H_AW  hidden buffer write address
- h_raddr  out  H_AW  hidden buffer read address
- w2_addr  out  W2_AW  layer-2 weight read address
- acc2_en  out  1  MAC2 accumulate enable, aligned to data
- mac2_start  out  1  one-cycle pulse: close current layer-2 sum
- mac2_done  in  1  MAC2 result valid
- out_valid  out  1  one-cycle pulse, class score ready
- sel  out  SEL_W  current output class index

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs and counters 0.
- State sequence: IDLE -> L1_RUN -> L1_FLUSH -> L1_WAIT -> L1_SIG -> (next neuron: L1_RUN | L2_RUN) -> L2_FLUSH -> L2_WAIT -> (next class: L2_RUN | FIN) -> IDLE.
- IDLE:
  - start=1 moves to L1_RUN next cycle and sets busy.
  - Neuron counter n, element counter i, w1_addr and in_addr are all cleared.
- L1_RUN, one element per cycle:
  - in_addr=i.
  - w1_addr is a free-running incrementer, equal to n*L1_IN+i. No multiplier.
  - acc1_en is the issue flag delayed SRAM_LAT cycles through a shift register.
  - At i=L1_IN-1, go to L1_FLUSH.
- L1_FLUSH:
  - Holds for SRAM_LAT cycles until the shift register drains.
  - Then mac1_start pulses for exactly 1 cycle; go to L1_WAIT.
- L1_WAIT: wait for mac1_done=1, then go to L1_SIG.
- L1_SIG:
  - On sig_ready=1: h_we=1 for one cycle with h_waddr=n.
  - If n=L1_OUT-1, go to L2_RUN with class k=0; otherwise n+1 and back to L1_RUN.
- L2_RUN / L2_FLUSH / L2_WAIT mirror the layer-1 states:
  - h_raddr=j; w2_addr=k*L2_IN+j (incrementer); acc2_en uses the same delay.
  - mac2_start pulses once after the flush.
  - On mac2_done: out_valid pulses with sel=k. If k=L2_OUT-1 go to FIN, otherwise k+1 and back to L2_RUN.
- FIN: done=1 for one cycle; busy=0 in the same cycle; back to IDLE.
- sel holds its last value until the next start; out_valid is the qualifier.
- mac1_done/mac2_done/sig_ready are only sampled in their wait states; otherwise ignored.
- start while busy is ignored.
- start in the FIN cycle is ignored; start is accepted only in IDLE.
- abort in any state: next cycle IDLE, counters cleared, all strobes 0, no done. abort has priority over start and over every other transition.
- Reset mid-operation: immediate return to the reset values; no partial h_we.
- Address widths: counters sized by parameters. Elaboration-time check that L1_IN*L1_OUT ≤ 2^W1_AW and L2_OUT*L1_OUT ≤ 2^W2_AW.

Decomposition:
- Shared package nn_pkg:
  - state enum
  - default layer sizes (784/200/10)
  - SRAM_LAT
  - address widths, also used by top and SRAM wrappers
- One sub-module, nn_addr_gen:
  - parameterised element counter plus base incrementer plus latency shift register
  - instantiated once per layer

Test Plan (L1_IN=4, L1_OUT=3, L2_OUT=2, SRAM_LAT=1, MAC/sigmoid models respond 2 cycles after request):
- Reset, then start:
  - w1_addr must run 0,1,2,3, then mac1_start; after sig_ready, h_we with h_waddr=0; next neuron w1_addr 4..7.
  - acc1_en must lag in_addr by exactly 1 cycle.
- Full run:
  - Exactly 3 h_we (addresses 0,1,2).
  - w2_addr sequence 0..2, then 3..5.
  - Two out_valid pulses with sel=0 then sel=1.
  - Then one done pulse with busy falling in the same cycle.
- Hold mac1_done low for 50 cycles:
  - Controller must stay in L1_WAIT with all addresses stable.
  - No h_we and no second mac1_start.
- Pulse start at cycle 10 of a run:
  - Sequence unchanged, one done only.
  - start on the done cycle is ignored; start one cycle later launches a new run.
- abort during L2_RUN (k=1, j=1):
  - Next cycle busy=0, all strobes 0, no done.
  - A following start restarts from w1_addr=0.
- Drive reset=0 asynchronously mid-L1_RUN:
  - Outputs 0 before the next clock edge.
  - After release, no activity until start.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the two-layer MLP sequencer: state encoding,
// default layer sizes, SRAM read latency and address widths.
package nn_pkg;

  localparam int unsigned NN_L1_IN    = 784;
  localparam int unsigned NN_L1_OUT   = 200;
  localparam int unsigned NN_L2_OUT   = 10;
  localparam int unsigned NN_W1_AW    = 18;
  localparam int unsigned NN_IN_AW    = 10;
  localparam int unsigned NN_W2_AW    = 12;
  localparam int unsigned NN_H_AW     = 8;
  localparam int unsigned NN_SEL_W    = 7;
  localparam int unsigned NN_SRAM_LAT = 1;

  typedef enum logic [3:0] {
    IDLE,
    L1_RUN,
    L1_FLUSH,
    L1_WAIT,
    L1_SIG,
    L2_RUN,
    L2_FLUSH,
    L2_WAIT,
    FIN
  } nn_state_e;

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Control/address bundle between the layer sequencer (master) and the
// SRAMs, MACs, sigmoid bank and output mux (slave).
interface nn_layer_sequencer_if
  import nn_pkg::*;
#(
  parameter int unsigned W1_AW = NN_W1_AW,
  parameter int unsigned IN_AW = NN_IN_AW,
  parameter int unsigned W2_AW = NN_W2_AW,
  parameter int unsigned H_AW  = NN_H_AW,
  parameter int unsigned SEL_W = NN_SEL_W
);

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [W1_AW-1:0] w1_addr;
  logic [IN_AW-1:0] in_addr;
  logic             acc1_en;
  logic             mac1_start;
  logic             mac1_done;
  logic             sig_ready;
  logic             h_we;
  logic [H_AW-1:0]  h_waddr;
  logic [H_AW-1:0]  h_raddr;
  logic [W2_AW-1:0] w2_addr;
  logic             acc2_en;
  logic             mac2_start;
  logic             mac2_done;
  logic             out_valid;
  logic [SEL_W-1:0] sel;

  modport master (
    input  start, abort, mac1_done, sig_ready, mac2_done,
    output busy, done, w1_addr, in_addr, acc1_en, mac1_start,
           h_we, h_waddr, h_raddr, w2_addr, acc2_en, mac2_start,
           out_valid, sel
  );

  modport slave (
    output start, abort, mac1_done, sig_ready, mac2_done,
    input  busy, done, w1_addr, in_addr, acc1_en, mac1_start,
           h_we, h_waddr, h_raddr, w2_addr, acc2_en, mac2_start,
           out_valid, sel
  );

endinterface

// File: rtl/nn_addr_gen.sv
// Per-layer address generator: element counter, free-running weight
// address incrementer (base + element without a multiplier) and the
// issue-to-data latency shift register that produces the MAC enable.
module nn_addr_gen #(
  parameter int unsigned CNT = 4,
  parameter int unsigned CW  = 2,
  parameter int unsigned AW  = 8,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          issue,
  output logic [CW-1:0] idx,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          en,
  output logic          drained
);

  assign last = (idx == CW'(CNT - 1));

  // Element index wraps per neuron; the weight address never rewinds, so it
  // lands on the next neuron's base after the last element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx  <= '0;
      addr <= '0;
    end else if (clr) begin
      idx  <= '0;
      addr <= '0;
    end else if (issue) begin
      idx  <= last ? '0 : idx + 1'b1;
      addr <= addr + 1'b1;
    end
  end

  if (LAT == 0) begin : g_no_lat
    assign en      = issue;
    assign drained = 1'b1;
  end else begin : g_lat
    logic [LAT-1:0] sr;

    // Delay the issue flag by the SRAM read latency.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sr <= '0;
      end else if (clr) begin
        sr <= '0;
      end else begin
        sr[0] <= issue;
        for (int unsigned b = 1; b < LAT; b++) sr[b] <= sr[b-1];
      end
    end

    assign en      = sr[LAT-1];
    assign drained = ~|sr;
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Two-layer MLP sequencer: walks layer 1 (weights x inputs -> sigmoid ->
// hidden buffer) and then layer 2 (hidden x weights -> class scores).
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned L1_IN    = NN_L1_IN,
  parameter int unsigned L1_OUT   = NN_L1_OUT,
  parameter int unsigned L2_OUT   = NN_L2_OUT,
  parameter int unsigned W1_AW    = NN_W1_AW,
  parameter int unsigned IN_AW    = NN_IN_AW,
  parameter int unsigned W2_AW    = NN_W2_AW,
  parameter int unsigned H_AW     = NN_H_AW,
  parameter int unsigned SEL_W    = NN_SEL_W,
  parameter int unsigned SRAM_LAT = NN_SRAM_LAT
) (
  input logic                  clk,
  input logic                  reset,
  nn_layer_sequencer_if.master bus
);

  if (64'(L1_IN) * 64'(L1_OUT) > (64'(1) << W1_AW)) begin : g_w1_range
    $error("L1_IN*L1_OUT exceeds the layer-1 weight address space");
  end
  if (64'(L2_OUT) * 64'(L1_OUT) > (64'(1) << W2_AW)) begin : g_w2_range
    $error("L2_OUT*L1_OUT exceeds the layer-2 weight address space");
  end

  nn_state_e        state, state_next;
  logic [H_AW-1:0]  n;
  logic [SEL_W-1:0] k;
  logic             n_last, k_last, clr;
  logic             g1_last, g1_drained, g2_last, g2_drained;

  assign n_last = (n == H_AW'(L1_OUT - 1));
  assign k_last = (k == SEL_W'(L2_OUT - 1));
  assign clr    = bus.abort || (state == IDLE);

  nn_addr_gen #(.CNT(L1_IN), .CW(IN_AW), .AW(W1_AW), .LAT(SRAM_LAT)) u_gen1 (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .issue  (state == L1_RUN),
    .idx    (bus.in_addr),
    .addr   (bus.w1_addr),
    .last   (g1_last),
    .en     (bus.acc1_en),
    .drained(g1_drained)
  );

  nn_addr_gen #(.CNT(L1_OUT), .CW(H_AW), .AW(W2_AW), .LAT(SRAM_LAT)) u_gen2 (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .issue  (state == L2_RUN),
    .idx    (bus.h_raddr),
    .addr   (bus.w2_addr),
    .last   (g2_last),
    .en     (bus.acc2_en),
    .drained(g2_drained)
  );

  assign bus.h_waddr = n;
  assign bus.sel     = k;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Neuron and class counters; sel keeps the last class until a new start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n <= '0;
      k <= '0;
    end else if (bus.abort || (state == IDLE && bus.start)) begin
      n <= '0;
      k <= '0;
    end else if (state == L1_SIG && bus.sig_ready && !n_last) begin
      n <= n + 1'b1;
    end else if (state == L2_WAIT && bus.mac2_done && !k_last) begin
      k <= k + 1'b1;
    end
  end

  // Next state and strobes; abort suppresses every strobe in its own cycle.
  always_comb begin
    state_next     = state;
    bus.busy       = (state != IDLE) && (state != FIN);
    bus.done       = 1'b0;
    bus.mac1_start = 1'b0;
    bus.mac2_start = 1'b0;
    bus.h_we       = 1'b0;
    bus.out_valid  = 1'b0;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (bus.start) state_next = L1_RUN;
        L1_RUN:   if (g1_last) state_next = L1_FLUSH;
        L1_FLUSH: if (g1_drained) begin
                    bus.mac1_start = 1'b1;
                    state_next     = L1_WAIT;
                  end
        L1_WAIT:  if (bus.mac1_done) state_next = L1_SIG;
        L1_SIG:   if (bus.sig_ready) begin
                    bus.h_we   = 1'b1;
                    state_next = n_last ? L2_RUN : L1_RUN;
                  end
        L2_RUN:   if (g2_last) state_next = L2_FLUSH;
        L2_FLUSH: if (g2_drained) begin
                    bus.mac2_start = 1'b1;
                    state_next     = L2_WAIT;
                  end
        L2_WAIT:  if (bus.mac2_done) begin
                    bus.out_valid = 1'b1;
                    state_next    = k_last ? FIN : L2_RUN;
                  end
        FIN:      begin
                    bus.done   = 1'b1;
                    state_next = IDLE;
                  end
        default:  state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for the layer sequencer with L1_IN=4, L1_OUT=3, L2_OUT=2,
// SRAM_LAT=1 and MAC/sigmoid models answering two cycles after request.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Cycle numbers below are loop iterations c.
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic hold_mac1 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] strb;

  nn_layer_sequencer_if bus ();

  nn_layer_sequencer #(
    .L1_IN   (4),
    .L1_OUT  (3),
    .L2_OUT  (2),
    .SRAM_LAT(1)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always_comb strb = {bus.busy, bus.done, bus.acc1_en, bus.mac1_start,
                      bus.h_we, bus.acc2_en, bus.mac2_start, bus.out_valid};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // MAC1/MAC2/sigmoid models: respond two cycles after their request.
  initial begin
    logic [1:0] p1, ps, p2;
    p1 = '0; ps = '0; p2 = '0;
    bus.mac1_done = 1'b0;
    bus.sig_ready = 1'b0;
    bus.mac2_done = 1'b0;
    forever begin
      @(negedge clk);
      p1 = {p1[0], bus.mac1_start};
      ps = {ps[0], bus.mac1_done};
      p2 = {p2[0], bus.mac2_start};
      @(posedge clk);
      #1;
      bus.mac1_done = p1[1] & ~hold_mac1;
      bus.sig_ready = ps[1];
      bus.mac2_done = p2[1];
    end
  end

  // First neuron, cycles 1..12 (index c-1).
  int exp_w1  [12] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 5};
  int exp_in  [12] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1};
  int exp_acc [12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
  int exp_m1s [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int exp_hwe [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    int hwe_cnt, ov_cnt, done_cnt, m1s_cnt, m2s_cnt;
    hwe_cnt = 0; ov_cnt = 0; done_cnt = 0; m1s_cnt = 0; m2s_cnt = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_strobes", strb, 0);
    check("reset_addr", {bus.w1_addr, bus.in_addr, bus.w2_addr}, 0);
    check("reset_idx", {bus.h_waddr, bus.h_raddr, bus.sel}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c <= 160; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == 0) || (c == 10) || (c == 45) || (c == 46) ||
                  (c == 106) || (c == 150);
      bus.abort = (c == 103) || (c == 145);
      if (c == 155) rst_n = 1'b1;
      @(negedge clk);

      if (c <= 46) begin
        hwe_cnt  += int'(bus.h_we);
        ov_cnt   += int'(bus.out_valid);
        done_cnt += int'(bus.done);
        m1s_cnt  += int'(bus.mac1_start);
        m2s_cnt  += int'(bus.mac2_start);
      end

      if (c == 0) check("idle_busy", bus.busy, 0);
      if (c >= 1 && c <= 12) begin
        check($sformatf("w1_addr@%0d", c), bus.w1_addr, exp_w1[c-1]);
        check($sformatf("in_addr@%0d", c), bus.in_addr, exp_in[c-1]);
        check($sformatf("acc1_en@%0d", c), bus.acc1_en, exp_acc[c-1]);
        check($sformatf("mac1_start@%0d", c), bus.mac1_start, exp_m1s[c-1]);
        check($sformatf("h_we@%0d", c), bus.h_we, exp_hwe[c-1]);
      end
      if (c == 10 || c == 20 || c == 30) begin
        check($sformatf("h_we@%0d", c), bus.h_we, 1);
        check($sformatf("h_waddr@%0d", c), bus.h_waddr, c / 10 - 1);
      end
      if (c >= 14 && c <= 14) check("w1_addr_n1_last", bus.w1_addr, 7);
      if (c >= 31 && c <= 33) begin
        check($sformatf("w2_addr@%0d", c), bus.w2_addr, c - 31);
        check($sformatf("h_raddr@%0d", c), bus.h_raddr, c - 31);
      end
      if (c >= 38 && c <= 40) begin
        check($sformatf("w2_addr@%0d", c), bus.w2_addr, c - 35);
        check($sformatf("h_raddr@%0d", c), bus.h_raddr, c - 38);
      end
      if (c >= 32 && c <= 34) check($sformatf("acc2_en@%0d", c), bus.acc2_en, 1);
      if (c == 35) begin
        check("acc2_en@35", bus.acc2_en, 0);
        check("mac2_start@35", bus.mac2_start, 1);
      end
      if (c == 42) check("mac2_start@42", bus.mac2_start, 1);
      if (c == 37) check("out0", {bus.out_valid, bus.sel}, {1'b1, 7'd0});
      if (c == 44) begin
        check("out1", {bus.out_valid, bus.sel}, {1'b1, 7'd1});
        check("busy_before_done", bus.busy, 1);
      end
      if (c == 45) check("done_cycle", {bus.done, bus.busy}, 2'b10);
      if (c == 46) begin
        check("start_on_done_ignored", bus.busy, 0);
        check("sel_hold", bus.sel, 1);
        check("h_we_count", hwe_cnt, 3);
        check("out_valid_count", ov_cnt, 2);
        check("done_count", done_cnt, 1);
        check("mac1_start_count", m1s_cnt, 3);
        check("mac2_start_count", m2s_cnt, 2);
      end
      if (c == 47) begin
        check("restart_busy", bus.busy, 1);
        check("restart_addr", {bus.w1_addr, bus.in_addr}, 0);
        hold_mac1 = 1'b1;
      end
      if (c == 48) check("restart_addr2", {bus.w1_addr, bus.in_addr}, {18'd1, 10'd1});
      if (c == 52) check("mac1_start_run2", bus.mac1_start, 1);
      if (c >= 53 && c <= 102)
        check($sformatf("hold@%0d", c),
              {bus.busy, bus.h_we, bus.mac1_start, bus.acc1_en, bus.in_addr, bus.w1_addr},
              {1'b1, 3'b000, 10'd0, 18'd4});
      if (c == 104) begin
        check("abort_wait_strobes", strb, 0);
        hold_mac1 = 1'b0;
      end
      if (c == 107) check("run3_start", {bus.busy, bus.w1_addr}, {1'b1, 18'd0});
      if (c == 145) check("run3_l2_k1_j1", {bus.busy, bus.w2_addr, bus.h_raddr},
                          {1'b1, 12'd4, 8'd1});
      if (c >= 146 && c <= 150) check($sformatf("abort_strobes@%0d", c), strb, 0);
      if (c == 151) check("post_abort_start",
                          {bus.busy, bus.w1_addr, bus.in_addr}, {1'b1, 18'd0, 10'd0});
      if (c == 152) check("post_abort_step", bus.w1_addr, 1);
      if (c == 153) begin
        check("pre_reset_w1", bus.w1_addr, 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_strobes", strb, 0);
        check("async_reset_addr", {bus.w1_addr, bus.in_addr, bus.w2_addr}, 0);
        check("async_reset_idx", {bus.h_waddr, bus.h_raddr}, 0);
      end
      if (c == 154) check("in_reset_strobes", strb, 0);
      if (c >= 156)
        check($sformatf("post_reset_idle@%0d", c), {strb, bus.w1_addr, bus.in_addr}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
